conv_dense_mac_engine: RTL and testbench

Parametrised successor to the conv1 layer-1 dense datapath. It pulls packed input-feature vectors from the global feature store over the need_data/data_v handshake and applies a per-output-channel coefficient vector to each one. It runs in one of two modes: lane-wise fixed-point multiply with saturation (elementwise), or multi-vector dot-product accumulation (dense/FC reduction). It sits between GLOBAL_IN_FEA and the downstream result writer.

---
 rtl/conv_dense_mac_engine_if.sv | 39 +++
 rtl/conv_dense_mac_engine.sv | 204 ++++++++++++++++++++
 tb/tb_conv_dense_mac_engine.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_dense_mac_engine_if.sv
// conv_dense_mac_engine_if
// Groups the run-control, feature-fetch, coefficient-load and result signals
// of conv_dense_mac_engine. clk and rst stay plain module ports.
//   master : driver side (start/mode, data_v/in_fea, coefficient writes)
//   slave  : engine side (need_data, results, busy/done)
interface conv_dense_mac_engine_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 25,
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 40
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int VEC_W = LANES * DATA_W;

  logic             start;
  logic             mode;
  logic             need_data;
  logic             data_v;
  logic [VEC_W-1:0] in_fea;
  logic             coef_we;
  logic [CH_W-1:0]  coef_ch;
  logic [VEC_W-1:0] coef_data;
  logic             res_v;
  logic [CH_W-1:0]  res_ch;
  logic [VEC_W-1:0] res_data;
  logic [ACC_W-1:0] acc_res;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, data_v, in_fea, coef_we, coef_ch, coef_data,
    input  need_data, res_v, res_ch, res_data, acc_res, busy, done
  );

  modport slave (
    input  start, mode, data_v, in_fea, coef_we, coef_ch, coef_data,
    output need_data, res_v, res_ch, res_data, acc_res, busy, done
  );
endinterface

// File: rtl/conv_dense_mac_engine.sv
// conv_dense_mac_engine
// Fetches DEPTH packed feature vectors over need_data/data_v and applies each
// of NUM_CH coefficient banks to every vector, one channel per cycle.
// Mode 0: per-lane fixed-point multiply, rescaled and saturated, one result
// per issue. Mode 1: per-channel dot product accumulated over the run, one
// result per channel after the last vector.
// Ports: clk, rst (synchronous, active low), bus (slave modport: start/mode,
// need_data/data_v/in_fea, coef_we/coef_ch/coef_data, res_v/res_ch/
// res_data/acc_res, busy/done).
module conv_dense_mac_engine #(
  parameter int DATA_W    = 16,
  parameter int LANES     = 25,
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 8,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40
) (
  input logic                   clk,
  input logic                   rst,
  conv_dense_mac_engine_if.slave bus
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int VEC_W  = LANES * DATA_W;
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [CH_W-1:0]    ch_reg;
  logic [CNT_W-1:0]   vec_reg;   // vectors accepted so far in this run
  logic               mode_reg;
  logic [VEC_W-1:0]   fea_reg;
  logic [VEC_W-1:0]   coef_mem [NUM_CH];
  logic signed [PROD_W-1:0] prod_reg [LANES];
  logic               s1_valid_reg, s1_last_reg;
  logic [CH_W-1:0]    s1_ch_reg;
  logic signed [ACC_W-1:0]  acc_reg [NUM_CH];
  logic               res_v_reg;
  logic [CH_W-1:0]    res_ch_reg;
  logic [VEC_W-1:0]   res_data_reg;
  logic [ACC_W-1:0]   acc_res_reg;

  logic need_data, busy, done, accept_start, accept_data, issue, coef_wr;
  logic [VEC_W-1:0]        coef_sel, ew_vec;
  logic signed [SUM_W-1:0] dot_sum;
  logic signed [ACC_W-1:0] acc_sum;

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    need_data    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    accept_start = 1'b0;
    accept_data  = 1'b0;
    issue        = 1'b0;
    coef_wr      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy    = 1'b0;
        coef_wr = bus.coef_we;
        if (bus.start) begin
          accept_start = 1'b1;
          state_next   = S_FETCH;
        end
      end
      S_FETCH: begin
        need_data = 1'b1;
        if (bus.data_v) begin
          accept_data = 1'b1;
          state_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue = 1'b1;
        if (ch_reg == CH_W'(NUM_CH - 1))
          state_next = (vec_reg < CNT_W'(DEPTH)) ? S_FETCH : S_DRAIN;
      end
      // Only stage 1 needs watching: once it is empty the last result is
      // already in the output register.
      S_DRAIN: if (!s1_valid_reg) state_next = S_DONE;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ch_reg   <= '0;
      vec_reg  <= '0;
      mode_reg <= 1'b0;
      fea_reg  <= '0;
    end else begin
      if (accept_start) begin
        mode_reg <= bus.mode;
        vec_reg  <= '0;
      end
      if (accept_data) begin
        fea_reg <= bus.in_fea;
        vec_reg <= vec_reg + CNT_W'(1);
        ch_reg  <= '0;
      end else if (issue) begin
        ch_reg <= ch_reg + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst) coef_mem[c] <= '0;
      else if (coef_wr && bus.coef_ch == CH_W'(c)) coef_mem[c] <= bus.coef_data;
    end
  end

  assign coef_sel = coef_mem[ch_reg];

  // Stage 1: full-width signed lane products.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_ch_reg    <= '0;
      for (int i = 0; i < LANES; i++) prod_reg[i] <= '0;
    end else begin
      s1_valid_reg <= issue;
      if (issue) begin
        s1_ch_reg   <= ch_reg;
        s1_last_reg <= (vec_reg == CNT_W'(DEPTH));
        for (int i = 0; i < LANES; i++)
          prod_reg[i] <= PROD_W'($signed(fea_reg[i*DATA_W +: DATA_W])) *
                         PROD_W'($signed(coef_sel[i*DATA_W +: DATA_W]));
      end
    end
  end

  // Stage 2 elementwise: arithmetic rescale then clamp to the lane range.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_sat
      logic signed [PROD_W-1:0] shifted;
      logic [DATA_W-1:0]        lane_sat;
      always_comb begin
        shifted  = prod_reg[gi] >>> FRAC_BITS;
        lane_sat = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX)      lane_sat = SAT_MAX[DATA_W-1:0];
        else if (shifted < SAT_MIN) lane_sat = SAT_MIN[DATA_W-1:0];
      end
      assign ew_vec[gi*DATA_W +: DATA_W] = lane_sat;
    end
  endgenerate

  // Stage 2 dot: lossless lane sum, then wrapping accumulate.
  always_comb begin
    dot_sum = '0;
    for (int i = 0; i < LANES; i++) dot_sum = dot_sum + SUM_W'(prod_reg[i]);
  end
  assign acc_sum = acc_reg[s1_ch_reg] + ACC_W'(dot_sum);

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst || accept_start) acc_reg[c] <= '0;
      else if (s1_valid_reg && mode_reg && s1_ch_reg == CH_W'(c)) acc_reg[c] <= acc_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      res_v_reg    <= 1'b0;
      res_ch_reg   <= '0;
      res_data_reg <= '0;
      acc_res_reg  <= '0;
    end else begin
      res_v_reg <= s1_valid_reg && (!mode_reg || s1_last_reg);
      if (s1_valid_reg && !mode_reg) begin
        res_ch_reg   <= s1_ch_reg;
        res_data_reg <= ew_vec;
        acc_res_reg  <= '0;
      end else if (s1_valid_reg && s1_last_reg) begin
        res_ch_reg   <= s1_ch_reg;
        res_data_reg <= '0;
        acc_res_reg  <= acc_sum;
      end
    end
  end

  assign bus.need_data = need_data;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.res_v     = res_v_reg;
  assign bus.res_ch    = res_ch_reg;
  assign bus.res_data  = res_data_reg;
  assign bus.acc_res   = acc_res_reg;
endmodule

// File: tb/tb_conv_dense_mac_engine.sv
module tb_conv_dense_mac_engine;
  localparam int DATA_W    = 16;
  localparam int LANES     = 25;
  localparam int NUM_CH    = 4;
  localparam int DEPTH     = 8;
  localparam int FRAC_BITS = 8;
  localparam int ACC_W     = 40;
  localparam int CH_W      = 2;
  localparam int VEC_W     = LANES * DATA_W;

  typedef struct {
    int               cyc;
    int               ch;
    logic [VEC_W-1:0] data;
    logic [ACC_W-1:0] acc;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   bank_m [NUM_CH][LANES];
  int   fea_m  [DEPTH][LANES];
  int   f_cyc  [DEPTH];
  res_t got_q[$];
  res_t mon_r;

  conv_dense_mac_engine_if #(.DATA_W(DATA_W), .LANES(LANES), .NUM_CH(NUM_CH), .ACC_W(ACC_W)) bus ();

  conv_dense_mac_engine #(
    .DATA_W(DATA_W), .LANES(LANES), .NUM_CH(NUM_CH), .DEPTH(DEPTH),
    .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.res_v === 1'b1) begin
      mon_r.cyc  = cyc;
      mon_r.ch   = int'(bus.res_ch);
      mon_r.data = bus.res_data;
      mon_r.acc  = bus.acc_res;
      got_q.push_back(mon_r);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rand_lane();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = DATA_W'(rand_lane());
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] pack_fea(input int v);
    logic [VEC_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = DATA_W'(fea_m[v][i]);
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] pack_bank(input int c);
    logic [VEC_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = DATA_W'(bank_m[c][i]);
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] ew_expect(input int v, input int c);
    logic [VEC_W-1:0] r;
    int q;
    for (int i = 0; i < LANES; i++) begin
      q = (fea_m[v][i] * bank_m[c][i]) >>> FRAC_BITS;
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      r[i*DATA_W +: DATA_W] = DATA_W'(q);
    end
    return r;
  endfunction

  function automatic logic [ACC_W-1:0] dot_expect(input int c);
    longint s = 0;
    for (int v = 0; v < DEPTH; v++)
      for (int i = 0; i < LANES; i++) s += longint'(fea_m[v][i]) * bank_m[c][i];
    return ACC_W'(s);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic load_bank(input int c);
    bus.coef_we = 1'b1;
    bus.coef_ch = CH_W'(c);
    bus.coef_data = pack_bank(c);
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  task automatic load_all_banks();
    for (int c = 0; c < NUM_CH; c++) load_bank(c);
  endtask

  task automatic rand_banks();
    for (int c = 0; c < NUM_CH; c++)
      for (int i = 0; i < LANES; i++) bank_m[c][i] = rand_lane();
    load_all_banks();
  endtask

  task automatic rand_feas();
    for (int v = 0; v < DEPTH; v++)
      for (int i = 0; i < LANES; i++) fea_m[v][i] = rand_lane();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_need"}, bus.need_data, 0);
    check({pfx, "_res_v"}, bus.res_v, 0);
    check({pfx, "_res_ch"}, bus.res_ch, 0);
    check({pfx, "_res_data"}, bus.res_data, 0);
    check({pfx, "_acc_res"}, bus.acc_res, 0);
    check({pfx, "_busy"}, bus.busy, 0);
    check({pfx, "_done"}, bus.done, 0);
  endtask

  task automatic compare_results(input bit m);
    int n_exp, v, c;
    logic [VEC_W-1:0] exp_data;
    logic [ACC_W-1:0] exp_acc;
    n_exp = m ? NUM_CH : DEPTH * NUM_CH;
    check("res_count", got_q.size(), n_exp);
    for (int k = 0; k < n_exp && k < got_q.size(); k++) begin
      if (m) begin
        v = DEPTH - 1; c = k; exp_data = '0; exp_acc = dot_expect(c);
      end else begin
        v = k / NUM_CH; c = k % NUM_CH; exp_data = ew_expect(v, c); exp_acc = '0;
      end
      check($sformatf("res_cyc[%0d]", k), got_q[k].cyc, f_cyc[v] + 3 + c);
      check($sformatf("res_ch[%0d]", k), got_q[k].ch, c);
      check($sformatf("res_data[%0d]", k), got_q[k].data, exp_data);
      check($sformatf("acc_res[%0d]", k), got_q[k].acc, exp_acc);
    end
  endtask

  // One complete run. stall: idle cycles in FETCH before data_v. noise: drive
  // data_v/start/coef_we while the engine is not fetching. hold: keep start
  // asserted through the end of the run.
  task automatic do_run(input bit m, input int stall, input bit noise, input bit hold);
    int guard;
    got_q.delete();
    bus.mode  = m;
    bus.start = 1'b1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("need_after_start", bus.need_data, 1);
    for (int v = 0; v < DEPTH; v++) begin
      guard = 0;
      while (bus.need_data !== 1'b1 && guard < 40) begin
        if (noise) begin
          bus.data_v    = 1'b1;
          bus.in_fea    = rand_vec();
          bus.start     = 1'b1;
          bus.coef_we   = 1'b1;
          bus.coef_ch   = CH_W'($urandom_range(0, NUM_CH - 1));
          bus.coef_data = rand_vec();
        end
        @(negedge clk);
        guard++;
        bus.data_v  = 1'b0;
        bus.coef_we = 1'b0;
        if (!hold) bus.start = 1'b0;
      end
      check("need_seen", bus.need_data, 1);
      if (v > 0) check("need_rise_cyc", cyc, f_cyc[v-1] + 1 + NUM_CH);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("need_held", bus.need_data, 1);
      end
      bus.data_v = 1'b1;
      bus.in_fea = pack_fea(v);
      f_cyc[v]   = cyc;
      @(negedge clk);
      bus.data_v = 1'b0;
      bus.in_fea = rand_vec();
      check("need_drop", bus.need_data, 0);
    end
    guard = 0;
    while (bus.done !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", bus.done, 1);
    check("done_cyc", cyc, f_cyc[DEPTH-1] + NUM_CH + 3);
    @(negedge clk);
    check("busy_clear", bus.busy, 0);
    check("done_pulse", bus.done, 0);
    compare_results(m);
    $display("run mode=%0d stall=%0d noise=%0d results=%0d errors=%0d", m, stall, noise, got_q.size(), errors);
  endtask

  initial begin
    logic [VEC_W-1:0] tmp;
    int guard;
    bus.start = 0; bus.mode = 0; bus.data_v = 0; bus.in_fea = '0;
    bus.coef_we = 0; bus.coef_ch = '0; bus.coef_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;
    @(negedge clk);

    // Elementwise identity: coefficient 1.0 in Q8, features i-12
    for (int c = 0; c < NUM_CH; c++)
      for (int i = 0; i < LANES; i++) bank_m[c][i] = 256;
    for (int v = 0; v < DEPTH; v++)
      for (int i = 0; i < LANES; i++) fea_m[v][i] = i - 12;
    load_all_banks();
    do_run(0, 0, 0, 0);
    if (got_q.size() > 5) begin
      tmp = got_q[5].data;
      check("ident_lane0", tmp[15:0], 16'hFFF4);
      check("ident_lane24", tmp[24*16 +: 16], 16'h000C);
    end

    // Saturation corners
    for (int i = 0; i < LANES; i++) begin
      bank_m[0][i] = 32767; bank_m[1][i] = 32767; bank_m[2][i] = -256; bank_m[3][i] = rand_lane();
    end
    rand_feas();
    for (int i = 0; i < LANES; i++) begin
      fea_m[0][i] = 32767; fea_m[1][i] = -32768; fea_m[2][i] = 2;
    end
    load_all_banks();
    do_run(0, 0, 0, 0);
    if (got_q.size() > 10) begin
      tmp = got_q[0].data;  check("sat_pos", tmp[15:0], 16'h7FFF);
      tmp = got_q[4].data;  check("sat_neg", tmp[15:0], 16'h8000);
      tmp = got_q[10].data; check("neg_coef", tmp[15:0], 16'hFFFE);
    end

    // Dot accumulate: features 1, bank c = c+1
    for (int c = 0; c < NUM_CH; c++)
      for (int i = 0; i < LANES; i++) bank_m[c][i] = c + 1;
    for (int v = 0; v < DEPTH; v++)
      for (int i = 0; i < LANES; i++) fea_m[v][i] = 1;
    load_all_banks();
    do_run(1, 0, 0, 0);
    for (int k = 0; k < NUM_CH && k < got_q.size(); k++)
      check($sformatf("dot_const[%0d]", k), got_q[k].acc, 200 * (k + 1));

    // Handshake: stalls and ignored inputs, then same data without stalls
    rand_banks();
    rand_feas();
    do_run(0, 5, 1, 0);
    do_run(0, 0, 0, 0);
    do_run(1, 2, 1, 0);

    // Reset during ISSUE of vector 3
    rand_banks();
    rand_feas();
    got_q.delete();
    bus.mode = 0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int v = 0; v < 4; v++) begin
      guard = 0;
      while (bus.need_data !== 1'b1 && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      check("mr_need", bus.need_data, 1);
      bus.data_v = 1'b1; bus.in_fea = pack_fea(v); f_cyc[v] = cyc;
      @(negedge clk);
      bus.data_v = 1'b0;
    end
    @(negedge clk);
    check("mr_pre_count", got_q.size(), 3 * NUM_CH);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_reset_outputs("mr");
    got_q.delete();
    bus.data_v = 1'b1;
    repeat (20) @(negedge clk);
    bus.data_v = 1'b0;
    check("mr_no_res", got_q.size(), 0);
    check("mr_idle", bus.busy, 0);
    $display("reset mid-run: results after reset=%0d", got_q.size());
    for (int c = 0; c < NUM_CH; c++)
      for (int i = 0; i < LANES; i++) bank_m[c][i] = 0;
    rand_feas();
    do_run(0, 0, 0, 0);
    rand_banks();
    do_run(0, 1, 0, 0);

    // Back-to-back dot runs with start held through done
    rand_banks();
    rand_feas();
    do_run(1, 0, 0, 1);
    rand_feas();
    do_run(1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
